// File: rtl/cam_capture_ctrl.sv
// Frame capture controller: locks to the camera frame start, tags pixels with
// SOF/EOL/EOF from a column/row count and queues them behind a valid/ready port.
module cam_capture_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int FIFO_AW = 3
) (
    input  logic        pclk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        continuous_i,
    input  logic        abort_i,
    input  logic        pix_valid_i,
    input  logic [15:0] pix_i,
    input  logic        vstart_i,
    input  logic        hstart_i,
    output logic        out_valid_o,
    output logic [15:0] out_data_o,
    output logic        out_sof_o,
    output logic        out_eol_o,
    output logic        out_eof_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_overflow_o,
    output logic        err_size_o,
    input  logic        clr_err_i,
    output logic [15:0] frame_cnt_o
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    state_t             state, state_next;
    logic [15:0]        col, row;
    logic [15:0]        eff_col, eff_row;
    logic               accept, sof, eol, eof, size_err;
    logic [18:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               fifo_empty, fifo_full, pop, push_ok, drop, drain_done;
    logic [18:0]        head;

    assign fifo_empty = (count == '0);
    assign fifo_full  = count[FIFO_AW];
    assign pop        = !fifo_empty && out_ready_i;
    assign push_ok    = accept && (!fifo_full || pop);
    assign drop       = accept && fifo_full && !pop;
    assign drain_done = (state == DRAIN) && fifo_empty && !abort_i;

    // Effective pixel position after applying frame/line resynchronisation.
    always_comb begin
        accept   = 1'b0;
        sof      = 1'b0;
        size_err = 1'b0;
        eff_col  = col;
        eff_row  = row;
        case (state)
            ARMED: begin
                if (pix_valid_i && vstart_i) begin
                    accept  = 1'b1;
                    sof     = 1'b1;
                    eff_col = '0;
                    eff_row = '0;
                end
            end
            CAPTURE: begin
                if (pix_valid_i) begin
                    accept = 1'b1;
                    if (vstart_i) begin
                        sof      = 1'b1;
                        size_err = 1'b1;
                        eff_col  = '0;
                        eff_row  = '0;
                    end else if (hstart_i && col != '0) begin
                        size_err = 1'b1;
                        eff_col  = '0;
                        eff_row  = row + 16'd1;
                    end
                end
            end
            default: ;
        endcase
        if (abort_i) begin
            accept   = 1'b0;
            size_err = 1'b0;
        end
        eol = (eff_col == 16'(IMG_W - 1));
        eof = eol && (eff_row == 16'(IMG_H - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = ARMED;
            ARMED:   if (accept) state_next = CAPTURE;
            CAPTURE: if (accept && eof) state_next = DRAIN;
            DRAIN:   if (fifo_empty) state_next = continuous_i ? ARMED : IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_i) state_next = IDLE;
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counters advance even when the FIFO drops the pixel, keeping tags aligned.
    always_ff @(posedge pclk_i) begin
        if (rst_i || abort_i || drain_done) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (eol) begin
                col <= '0;
                row <= eff_row + 16'd1;
            end else begin
                col <= eff_col + 16'd1;
                row <= eff_row;
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (push_ok && !rst_i) mem[wr_ptr] <= {eof, eol, sof, pix_i};
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i || abort_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A fresh error in the clearing cycle keeps the flag set.
    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            err_overflow_o <= 1'b0;
            err_size_o     <= 1'b0;
            done_o         <= 1'b0;
            frame_cnt_o    <= '0;
        end else begin
            err_overflow_o <= (err_overflow_o && !clr_err_i) || drop;
            err_size_o     <= (err_size_o && !clr_err_i) || size_err;
            done_o         <= drain_done;
            if (drain_done) frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end

    assign head        = mem[rd_ptr];
    assign out_valid_o = !fifo_empty;
    assign out_data_o  = fifo_empty ? 16'h0 : head[15:0];
    assign out_sof_o   = !fifo_empty && head[16];
    assign out_eol_o   = !fifo_empty && head[17];
    assign out_eof_o   = !fifo_empty && head[18];
    assign busy_o      = (state != IDLE);

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Frame capture controller sitting between the RGB565 camera receiver and the downstream pixel consumer (frame buffer writer / stream pipeline). It arms on command and locks to the receiver's frame-start marker. It counts columns and rows against the configured image size, tags pixels with SOF/EOL/EOF, and buffers them in a small FIFO behind a valid/ready output. It reports completion, overflow and geometry errors.

Parameters:
IMG_W, 640, expected pixels per line (>=2)
IMG_H, 480, expected lines per frame (>=1)
FIFO_AW, 3, FIFO address width; depth = 2^FIFO_AW entries of 19 bits (pixel + sof + eol + eof)

Ports:
pclk_i  in  1  pixel clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  pulse: arm a capture (honoured only in IDLE)
continuous_i  in  1  1 = re-arm automatically after each frame
abort_i  in  1  pulse: abandon capture, flush FIFO
pix_valid_i  in  1  receiver pixelReady strobe
pix_i  in  16  RGB565 pixel, valid with pix_valid_i
vstart_i  in  1  first pixel of frame, qualified by pix_valid_i
hstart_i  in  1  first pixel of line, qualified by pix_valid_i
out_valid_o  out  1  FIFO head valid
out_data_o  out  16  head pixel
out_sof_o / out_eol_o / out_eof_o  out  1 each  head tags
out_ready_i  in  1  consumer accepts head
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse, frame fully drained
err_overflow_o  out  1  sticky: pixel dropped, FIFO full
err_size_o  out  1  sticky: line or frame geometry mismatch
clr_err_i  in  1  clears both sticky flags
frame_cnt_o  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset: state IDLE; FIFO empty; col/row = 0; all outputs 0; frame_cnt_o = 0.
- States:
  - IDLE: start_i -> ARMED.
  - ARMED: pixels are ignored until pix_valid_i && vstart_i. That pixel is pushed as (0,0) with sof=1, and the state moves to CAPTURE.
  - CAPTURE: each pix_valid_i pushes one entry.
  - DRAIN: entered after the eof pixel is pushed. When the FIFO is empty: done_o=1 for one cycle, frame_cnt_o+1, then ARMED if continuous_i else IDLE.
- Counters in CAPTURE:
  - Tags: eol=1 when col==IMG_W-1; eof=1 when additionally row==IMG_H-1.
  - At col==IMG_W-1: col->0, row+1. Otherwise col+1.
  - hstart_i with col!=0: set err_size_o. The pixel is treated as col 0 of the next row; the previous line gets no eol.
  - vstart_i in CAPTURE (premature frame): set err_size_o, reset col/row, push the pixel with sof=1. The current frame continues as a new frame with no done for the truncated one.
- abort_i in any state: next state IDLE, FIFO flushed, counters cleared, no done_o. abort_i beats start_i on the same cycle. start_i outside IDLE is ignored.
- FIFO push/pop:
  - Push on accepted pixel.
  - If the FIFO is full and no pop occurs that cycle, the pixel is dropped and err_overflow_o is set. The counters still advance, so geometry and tags stay aligned.
  - Full with a simultaneous pop: the push succeeds.
- Output handshake:
  - out_valid_o = FIFO not empty. Transfer when out_valid_o && out_ready_i.
  - Data and tags are held stable while valid && !ready. A transfer can occur every cycle.
- Latency: a pixel accepted at edge N into an empty FIFO is visible on out_* after edge N (registered FIFO, first-word fall-through).
- Sticky errors: clr_err_i clears them. A new error in the same cycle as clr_err_i wins and the flag stays 1. Errors do not stop capture.
- pix_valid_i is ignored in IDLE and DRAIN. A pixel arriving in DRAIN is discarded with no error.

Test Plan:
- Basic frame (IMG_W=4, IMG_H=2), out_ready_i=1: start_i, then 8 pixels 0x0001..0x0008 with vstart on the first and hstart on the 1st and 5th -> outputs 0x0001 (sof), 0x0004 (eol), 0x0008 (eol+eof); done_o pulses once after the last pop; frame_cnt_o=1; back to IDLE.
- Arming: pixels before vstart are dropped. Two frames with continuous_i=1 -> frame_cnt_o=2, each frame's first output carries sof, no errors.
- Backpressure (FIFO_AW=2): out_ready_i=0 through a 4x2 frame -> 4 entries held, last 4 pixels dropped, err_overflow_o=1. Releasing ready drains 0x0001..0x0004 in order, then done_o pulses. clr_err_i -> flag returns to 0.
- Geometry: hstart on the 3rd pixel of line 0 -> err_size_o=1, and the 3rd pixel is counted as col 0 of row 1. Early vstart mid-frame -> err_size_o=1, and that pixel is output with sof=1.
- Abort mid-frame with 3 entries queued -> out_valid_o=0 next cycle, busy_o=0, no done_o. start_i+abort_i on the same cycle -> stays IDLE.
- Reset mid-CAPTURE -> all outputs 0 and FIFO empty on the following cycle; frame_cnt_o=0.
